// File: rtl/lvtram_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle for the LVT RAM port arbiter.
// slave: the arbiter's view; master: the requesters/RAM (testbench) view.
interface lvtram_port_arbiter_if #(
    parameter int NUM_REQ           = 4,
    parameter int NUM_OF_READ_PORT  = 2,
    parameter int NUM_OF_WRITE_PORT = 2,
    parameter int RAM_WIDTH         = 64,
    parameter int RAM_DEPTH         = 128,
    parameter int RAM_WIDTH_BYTE    = RAM_WIDTH / 8,
    parameter int RAM_IDX_WIDTH     = $clog2(RAM_DEPTH)
);
    // requester side
    logic [NUM_REQ-1:0]                         req_valid;
    logic [NUM_REQ-1:0]                         req_ready;
    logic [NUM_REQ-1:0]                         req_we;
    logic [NUM_REQ-1:0][RAM_IDX_WIDTH-1:0]      req_idx;
    logic [NUM_REQ-1:0][RAM_WIDTH-1:0]          req_data;
    logic [NUM_REQ-1:0][RAM_WIDTH_BYTE-1:0]     req_mask;
    logic [NUM_REQ-1:0]                         resp_valid;
    logic [NUM_REQ-1:0][RAM_WIDTH-1:0]          resp_data;
    logic                                       init_busy;

    // RAM side
    logic [NUM_OF_READ_PORT-1:0]                      r_en;
    logic [NUM_OF_READ_PORT-1:0][RAM_IDX_WIDTH-1:0]   r_ram_idx;
    logic [NUM_OF_READ_PORT-1:0][RAM_WIDTH-1:0]       r_data;
    logic [NUM_OF_WRITE_PORT-1:0]                     w_en;
    logic [NUM_OF_WRITE_PORT-1:0][RAM_IDX_WIDTH-1:0]  w_ram_idx;
    logic [NUM_OF_WRITE_PORT-1:0][RAM_WIDTH-1:0]      w_data;
    logic [NUM_OF_WRITE_PORT-1:0][RAM_WIDTH_BYTE-1:0] w_mask;

    modport slave (
        input  req_valid, req_we, req_idx, req_data, req_mask, r_data,
        output req_ready, resp_valid, resp_data, init_busy,
               r_en, r_ram_idx, w_en, w_ram_idx, w_data, w_mask
    );

    modport master (
        output req_valid, req_we, req_idx, req_data, req_mask, r_data,
        input  req_ready, resp_valid, resp_data, init_busy,
               r_en, r_ram_idx, w_en, w_ram_idx, w_data, w_mask
    );
endinterface

// File: rtl/lvtram_port_arbiter.sv
// Round-robin arbiter sharing the read/write ports of a multi-port LVT RAM
// among NUM_REQ requesters. Read data returns one cycle after grant; a write
// granted in the same cycle as a read of the same index is merged into the
// returned data, so the RAM itself needs no write-to-read bypass.
// Optional: define LVTRAM_ARB_INIT_EN to zero-fill the RAM after reset.
module lvtram_port_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int NUM_OF_READ_PORT  = 2,
    parameter int NUM_OF_WRITE_PORT = 2,
    parameter int RAM_WIDTH         = 64,
    parameter int RAM_DEPTH         = 128,
    parameter int RAM_WIDTH_BYTE    = RAM_WIDTH / 8,
    parameter int RAM_IDX_WIDTH     = $clog2(RAM_DEPTH)
) (
    input logic                  clock,
    input logic                  reset,
    lvtram_port_arbiter_if.slave bus
);
    localparam int RQW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NR  = NUM_OF_READ_PORT;
    localparam int NW  = NUM_OF_WRITE_PORT;

    logic                              run;
    logic [RQW-1:0]                    rr_ptr, rr_next;
    logic [NR-1:0][RQW-1:0]            rd_owner;
    logic [NR-1:0][RAM_WIDTH-1:0]      byp_data_d, byp_bmask_d;

    // one entry per read port: who asked, plus same-cycle write data to merge
    logic [NR-1:0]                     rsp_vld;
    logic [NR-1:0][RQW-1:0]            rsp_req;
    logic [NR-1:0][RAM_WIDTH-1:0]      byp_data, byp_bmask;
    logic [NUM_REQ-1:0][RAM_WIDTH-1:0] resp_hold;

`ifdef LVTRAM_ARB_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t                 state, state_next;
    logic [RAM_IDX_WIDTH:0] cnt, cnt_next;

    // sweep state register; reset restarts the sweep from index 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // advance the sweep one write-port-width per cycle, then run forever
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == ST_INIT) begin
            if (int'(cnt) + NW >= RAM_DEPTH) begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + (RAM_IDX_WIDTH+1)'(NW);
            end
        end
    end

    assign run           = (state == ST_RUN);
    assign bus.init_busy = (state == ST_INIT);
`else
    assign run           = 1'b1;
    assign bus.init_busy = 1'b0;
`endif

    // round-robin scan: each valid request takes the lowest free port of its kind
    always_comb begin
        logic [RQW-1:0] req;
        logic           taken;
        logic           conflict;
        bus.req_ready = '0;
        bus.r_en      = '0;
        bus.r_ram_idx = '0;
        bus.w_en      = '0;
        bus.w_ram_idx = '0;
        bus.w_data    = '0;
        bus.w_mask    = '0;
        rd_owner      = '0;
        rr_next       = rr_ptr;
        req           = '0;
        taken         = 1'b0;
        conflict      = 1'b0;
        if (!run) begin
`ifdef LVTRAM_ARB_INIT_EN
            for (int k = 0; k < NW; k++) begin
                if (int'(cnt) + k < RAM_DEPTH) begin
                    bus.w_en[k]      = 1'b1;
                    bus.w_ram_idx[k] = RAM_IDX_WIDTH'(int'(cnt) + k);
                    bus.w_mask[k]    = '1;
                end
            end
`endif
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                req   = RQW'((int'(rr_ptr) + k) % NUM_REQ);
                taken = 1'b0;
                if (bus.req_valid[req] && !bus.req_we[req]) begin
                    for (int p = 0; p < NR; p++) begin
                        if (!taken && !bus.r_en[p]) begin
                            bus.r_en[p]      = 1'b1;
                            bus.r_ram_idx[p] = bus.req_idx[req];
                            rd_owner[p]      = req;
                            taken            = 1'b1;
                        end
                    end
                end else if (bus.req_valid[req]) begin
                    // two writes to one index in a cycle would race in the RAM
                    conflict = 1'b0;
                    for (int j = 0; j < NW; j++)
                        if (bus.w_en[j] && bus.w_ram_idx[j] == bus.req_idx[req])
                            conflict = 1'b1;
                    for (int j = 0; j < NW; j++) begin
                        if (!conflict && !taken && !bus.w_en[j]) begin
                            bus.w_en[j]      = 1'b1;
                            bus.w_ram_idx[j] = bus.req_idx[req];
                            bus.w_data[j]    = bus.req_data[req];
                            bus.w_mask[j]    = bus.req_mask[req];
                            taken            = 1'b1;
                        end
                    end
                end
                if (taken) begin
                    bus.req_ready[req] = 1'b1;
                    rr_next            = RQW'((int'(req) + 1) % NUM_REQ);
                end
            end
        end
    end

    // capture granted same-cycle writes that hit a granted read's index
    always_comb begin
        byp_data_d  = '0;
        byp_bmask_d = '0;
        for (int p = 0; p < NR; p++)
            for (int j = 0; j < NW; j++)
                if (bus.r_en[p] && bus.w_en[j] && bus.r_ram_idx[p] == bus.w_ram_idx[j]) begin
                    byp_data_d[p] = bus.w_data[j];
                    for (int b = 0; b < RAM_WIDTH_BYTE; b++)
                        byp_bmask_d[p][8*b +: 8] = {8{bus.w_mask[j][b]}};
                end
    end

    // pointer and response-routing registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            rsp_vld   <= '0;
            rsp_req   <= '0;
            byp_data  <= '0;
            byp_bmask <= '0;
            resp_hold <= '0;
        end else begin
            rr_ptr    <= rr_next;
            rsp_vld   <= bus.r_en;
            rsp_req   <= rd_owner;
            byp_data  <= byp_data_d;
            byp_bmask <= byp_bmask_d;
            resp_hold <= bus.resp_data;
        end
    end

    // route returning RAM data to its requester; otherwise hold the last value
    always_comb begin
        bus.resp_valid = '0;
        bus.resp_data  = resp_hold;
        for (int p = 0; p < NR; p++)
            if (rsp_vld[p]) begin
                bus.resp_valid[rsp_req[p]] = 1'b1;
                bus.resp_data[rsp_req[p]]  = (byp_data[p] & byp_bmask[p]) |
                                             (bus.r_data[p] & ~byp_bmask[p]);
            end
    end
endmodule

// File: doc/lvtram_port_arbiter.md
Name: lvtram_port_arbiter

Overview:
- Shares the read and write ports of the multi-port LVT RAM among NUM_REQ requesters.
- Each cycle, valid requests are granted onto free RAM ports in round-robin order, with a valid/ready handshake per requester.
- Read data is routed back to the issuing requester one cycle after grant.
- An optional post-reset init sweep zero-fills the RAM so the storage needs no reset network (SRAM-portable).

Parameters:
- NUM_REQ, 4, number of requesters
- NUM_OF_READ_PORT, 2, RAM read ports
- NUM_OF_WRITE_PORT, 2, RAM write ports
- RAM_WIDTH, 64, data width in bits
- RAM_DEPTH, 128, entries
- RAM_WIDTH_BYTE, RAM_WIDTH/8, mask width
- RAM_IDX_WIDTH, $clog2(RAM_DEPTH), index width

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid[NUM_REQ]  in  1  request present
- req_ready[NUM_REQ]  out  1  request granted this cycle
- req_we[NUM_REQ]  in  1  1=write, 0=read
- req_idx[NUM_REQ]  in  RAM_IDX_WIDTH  entry index
- req_data[NUM_REQ]  in  RAM_WIDTH  write data
- req_mask[NUM_REQ]  in  RAM_WIDTH_BYTE  write byte mask
- resp_valid[NUM_REQ]  out  1  read data valid
- resp_data[NUM_REQ]  out  RAM_WIDTH  read data
- init_busy  out  1  init sweep in progress
- r_en[NUM_OF_READ_PORT], r_ram_idx[...]  out  1 / RAM_IDX_WIDTH  to RAM read ports
- r_data[NUM_OF_READ_PORT]  in  RAM_WIDTH  from RAM, one cycle after r_en
- w_en, w_ram_idx, w_data, w_mask [NUM_OF_WRITE_PORT]  out  1 / RAM_IDX_WIDTH / RAM_WIDTH / RAM_WIDTH_BYTE  to RAM write ports

Behaviour:
- Reset is asynchronous and active-high; clock is clock.
- Reset values:
  - rr_ptr=0, resp_valid all 0, resp_data 0, response-routing registers cleared.
  - FSM state = INIT if the optional feature is compiled in, else RUN.
- FSM:
  - INIT: req_ready all 0; init_busy=1. Write port k drives w_en=1, idx=cnt+k, data=0, mask all ones; ports whose idx ≥ RAM_DEPTH drive w_en=0. r_en all 0.
  - INIT step: cnt advances by NUM_OF_WRITE_PORT each cycle. When cnt+NUM_OF_WRITE_PORT ≥ RAM_DEPTH, go to RUN next cycle and reset cnt to 0.
  - RUN: init_busy=0. State is held until reset.
- Arbitration in RUN (combinational, same cycle):
  - Scan requesters in order rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Valid read: granted onto the lowest free read port; if none is free, not granted.
  - Valid write: granted onto the lowest free write port, unless its idx equals an already-granted write's idx this cycle (write-write conflict) or no port is free.
  - Scanning continues past a non-granted requester; there is no head-of-line blocking.
  - req_ready[i]=1 only if the request is granted. req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
  - Transfer occurs when req_valid & req_ready. Unused ports drive en=0 and idx/data/mask=0.
  - rr_ptr update: if at least one grant, rr_ptr ← (last granted requester in scan order + 1) mod NUM_REQ; otherwise held.
- Responses:
  - A read granted in cycle t drives resp_valid[i]=1 in cycle t+1, with resp_data[i]=r_data[assigned port].
  - Port→requester mapping is registered at t. Back-to-back reads by one requester give back-to-back responses.
  - resp_data holds its last value when resp_valid=0.
- Ordering:
  - A same-cycle write and read to one idx: read returns the new data (RAM bypass).
  - A write granted in cycle t is visible to reads granted in cycle ≥ t.
- Reset mid-operation: in-flight responses are dropped (resp_valid=0). With the feature compiled in, the sweep restarts from idx 0.

Optional Feature:
- Macro: LVTRAM_ARB_INIT_EN.
- Defined: reset enters INIT; the zero-fill sweep takes ceil(RAM_DEPTH/NUM_OF_WRITE_PORT) cycles before any grant.
- Undefined: no INIT state or cnt logic; reset enters RUN directly; init_busy is tied to 0.

Test Plan:
- Init sweep (feature on, defaults): deassert reset → init_busy=1 for exactly 64 cycles. Port0/port1 write idx 0/1, 2/3 … 126/127 with data 0 and mask 0xFF. req_ready stays 0 throughout. Cycle 65: grants possible.
- Read fairness: rr_ptr=0, all 4 requesters read idx 3,4,5,6 → cycle t grants req0→port0, req1→port1, rr_ptr=2. t+1: resp_valid[0,1]=1 with data of idx 3,4; req2,req3 granted. t+2: their responses.
- Write conflict: req0 and req1 both write idx 5 (data 0x11…, 0x22…) → only req0 granted, rr_ptr=1. Next cycle req1 granted; later read of idx 5 returns 0x22…22.
- Bypass: req0 writes idx 9 data 0xAAAA_AAAA_AAAA_AAAA with mask 0xFF; same cycle req1 reads idx 9 → next cycle resp_valid[1]=1, resp_data[1]=0xAAAA_AAAA_AAAA_AAAA.
- Mixed: req0 read, req1 write, req2 read, req3 write → all four granted in one cycle, ports 0/1 of each kind in scan order; rr_ptr returns to 0.
- Reset mid-op: read granted in cycle t, reset asserted before edge t+1 → resp_valid stays 0, rr_ptr=0; init_busy=1 again with the feature on.
